tpu_lanes: RTL and testbench

Parametrised second-generation matrix-multiply unit. Computes C = A·B, or C = C + A·B, over DIM×DIM signed operand matrices held in internal flop storage. Uses LANES parallel MAC lanes, selectable wrap or saturating write-back, and a busy/done handshake. Host-side access is row/col addressed, so a controller or bench loads A, B and C, pulses start, and reads C back element by element.

---
 rtl/tpu_pkg.sv | 39 +++
 rtl/tpu_lanes_mac_lane.sv | 36 +++
 rtl/tpu_lanes.sv | 243 ++++++++++++++++++++++++
 tb/tb_tpu_lanes.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the tpu_lanes matrix-multiply unit.
// Holds the controller state encoding and width/saturation helpers.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        FIN  = 2'd3
    } tpu_state_e;

    // Working width for saturate(); must cover any write-back sum width.
    localparam int SAT_W = 128;

    function automatic int acc_width(input int bits_ab, input int dim);
        return 2 * bits_ab + $clog2(dim);
    endfunction

    // Clamp a signed value into the signed range of bits_c bits.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] s,
        input int                      bits_c
    );
        logic signed [SAT_W-1:0] one_v;
        logic signed [SAT_W-1:0] hi_v;
        logic signed [SAT_W-1:0] lo_v;
        one_v = 128'sd1;
        hi_v  = (one_v <<< (bits_c - 1)) - one_v;
        lo_v  = -hi_v - one_v;
        if (s > hi_v) begin
            return hi_v;
        end else if (s < lo_v) begin
            return lo_v;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/tpu_lanes_mac_lane.sv
// One multiply-accumulate lane: acc += a*b when enabled, with clear.
// The accumulator is wide enough that a full dot product cannot overflow.
module mac_lane
    import tpu_pkg::*;
#(
    parameter int BITS_AB = 16,
    parameter int AW      = 35
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic signed [BITS_AB-1:0] a,
    input  logic signed [BITS_AB-1:0] b,
    output logic signed [AW-1:0]      acc
);

    logic signed [2*BITS_AB-1:0] prod_s;
    logic signed [AW-1:0]        acc_r;

    assign prod_s = a * b;

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {AW{1'b0}};
        end else if (clr) begin
            acc_r <= {AW{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + {{(AW-2*BITS_AB){prod_s[2*BITS_AB-1]}}, prod_s};
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/tpu_lanes.sv
// Matrix-multiply unit: C = A*B or C = C + A*B over DIM x DIM flop arrays,
// LANES columns computed in parallel, wrap or saturating write-back.
module tpu_lanes
    import tpu_pkg::*;
#(
    parameter int BITS_AB = 16,
    parameter int BITS_C  = 32,
    parameter int DIM     = 8,
    parameter int LANES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode_acc,
    input  logic                     mode_sat,
    input  logic                     WrEnA,
    input  logic                     WrEnB,
    input  logic                     WrEnC,
    input  logic [$clog2(DIM)-1:0]   row,
    input  logic [$clog2(DIM)-1:0]   col,
    input  logic [BITS_C-1:0]        dataIn,
    output logic [BITS_C-1:0]        dataOut,
    output logic                     busy,
    output logic                     done
);

    localparam int CW    = $clog2(DIM);
    localparam int NG    = DIM / LANES;
    localparam int JGW   = (NG > 1) ? $clog2(NG) : 1;
    localparam int AW    = acc_width(BITS_AB, DIM);
    localparam int SUM_W = ((AW > BITS_C) ? AW : BITS_C) + 1;

    logic signed [BITS_AB-1:0] a_mem_r [DIM][DIM];
    logic signed [BITS_AB-1:0] b_mem_r [DIM][DIM];
    logic signed [BITS_C-1:0]  c_mem_r [DIM][DIM];

    tpu_state_e       state_r;
    tpu_state_e       state_next_s;
    logic [CW-1:0]    i_r;
    logic [CW-1:0]    k_r;
    logic [JGW-1:0]   jg_r;
    logic             mode_acc_r;
    logic             mode_sat_r;
    logic [BITS_C-1:0] data_out_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             host_wr_s;
    logic             k_last_s;
    logic             jg_last_s;
    logic             i_last_s;
    logic             lane_clr_s;
    logic             lane_en_s;

    logic [CW-1:0]             lane_col_s [LANES];
    logic signed [AW-1:0]      acc_s      [LANES];
    logic signed [SUM_W-1:0]   sum_s      [LANES];
    logic signed [SAT_W-1:0]   sat_s      [LANES];
    logic [BITS_C-1:0]         wb_val_s   [LANES];

    assign host_wr_s  = (state_r == IDLE);
    assign accept_s   = (state_r == IDLE) && start;
    assign k_last_s   = (k_r == CW'(DIM - 1));
    assign jg_last_s  = (jg_r == JGW'(NG - 1));
    assign i_last_s   = (i_r == CW'(DIM - 1));
    assign lane_clr_s = accept_s || (state_r == WB);
    assign lane_en_s  = (state_r == MAC);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: MAC runs DIM cycles, then a single write-back cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = MAC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC: begin
                if (k_last_s) begin
                    state_next_s = WB;
                end else begin
                    state_next_s = MAC;
                end
            end
            WB: begin
                if (jg_last_s && i_last_s) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = MAC;
                end
            end
            FIN:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Loop counters and latched operating modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r        <= {CW{1'b0}};
            k_r        <= {CW{1'b0}};
            jg_r       <= {JGW{1'b0}};
            mode_acc_r <= 1'b0;
            mode_sat_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        i_r        <= {CW{1'b0}};
                        k_r        <= {CW{1'b0}};
                        jg_r       <= {JGW{1'b0}};
                        mode_acc_r <= mode_acc;
                        mode_sat_r <= mode_sat;
                    end
                end
                MAC: begin
                    k_r <= k_last_s ? {CW{1'b0}} : k_r + CW'(1);
                end
                WB: begin
                    if (jg_last_s) begin
                        jg_r <= {JGW{1'b0}};
                        i_r  <= i_r + CW'(1);
                    end else begin
                        jg_r <= jg_r + JGW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status: busy spans MAC through FIN, done marks FIN only.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == FIN);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_col_s[l] = CW'(int'(jg_r) * LANES + l);

        mac_lane #(
            .BITS_AB (BITS_AB),
            .AW      (AW)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr_s),
            .en  (lane_en_s),
            .a   (a_mem_r[i_r][k_r]),
            .b   (b_mem_r[k_r][lane_col_s[l]]),
            .acc (acc_s[l])
        );
    end

    // Write-back value per lane: optional C addend, then wrap or clamp.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum_s[l]    = {{(SUM_W-AW){acc_s[l][AW-1]}}, acc_s[l]};
            sat_s[l]    = {SAT_W{1'b0}};
            wb_val_s[l] = {BITS_C{1'b0}};
            if (mode_acc_r) begin
                sum_s[l] = sum_s[l] + {{(SUM_W-BITS_C){c_mem_r[i_r][lane_col_s[l]][BITS_C-1]}},
                                       c_mem_r[i_r][lane_col_s[l]]};
            end else begin
                sum_s[l] = sum_s[l];
            end
            sat_s[l] = saturate({{(SAT_W-SUM_W){sum_s[l][SUM_W-1]}}, sum_s[l]}, BITS_C);
            if (mode_sat_r) begin
                wb_val_s[l] = sat_s[l][BITS_C-1:0];
            end else begin
                wb_val_s[l] = sum_s[l][BITS_C-1:0];
            end
        end
    end

    // A and B operand storage; host writes only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_mem_r[r][c] <= {BITS_AB{1'b0}};
                    b_mem_r[r][c] <= {BITS_AB{1'b0}};
                end
            end
        end else if (host_wr_s) begin
            if (WrEnA) begin
                a_mem_r[row][col] <= dataIn[BITS_AB-1:0];
            end
            if (WrEnB) begin
                b_mem_r[row][col] <= dataIn[BITS_AB-1:0];
            end
        end
    end

    // C storage: lane write-back during WB, host writes while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    c_mem_r[r][c] <= {BITS_C{1'b0}};
                end
            end
        end else if (state_r == WB) begin
            for (int l = 0; l < LANES; l++) begin
                c_mem_r[i_r][lane_col_s[l]] <= wb_val_s[l];
            end
        end else if (host_wr_s && WrEnC) begin
            c_mem_r[row][col] <= dataIn;
        end
    end

    // Registered readback of C; reflects partial results while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= {BITS_C{1'b0}};
        end else begin
            data_out_r <= c_mem_r[row][col];
        end
    end

    assign dataOut = data_out_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_tpu_lanes.sv
// Self-checking bench for tpu_lanes: random matrices against a plain
// arithmetic reference, plus saturation, protocol, abort and DIM=4 sweeps.
module tb_tpu_lanes;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_acc;
    logic        mode_sat;
    logic        WrEnA;
    logic        WrEnB;
    logic        WrEnC;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [31:0] dataIn;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic [31:0] dout2;
    logic [31:0] dout3;
    logic [3:0]  busy_all;
    logic [3:0]  done_all;

    int tests = 0;
    int fails = 0;
    int dcyc [4];
    int np   [4];

    int                 am [8][8];
    int                 bm [8][8];
    logic signed [31:0] cm [8][8];

    always #5 clk = ~clk;

    tpu_lanes dut (
        .clk(clk), .rst(rst), .start(start), .mode_acc(mode_acc), .mode_sat(mode_sat),
        .WrEnA(WrEnA), .WrEnB(WrEnB), .WrEnC(WrEnC), .row(row), .col(col),
        .dataIn(dataIn), .dataOut(dout0), .busy(busy_all[0]), .done(done_all[0])
    );

    tpu_lanes #(.DIM(4), .LANES(1)) dut4_l1 (
        .clk(clk), .rst(rst), .start(start), .mode_acc(mode_acc), .mode_sat(mode_sat),
        .WrEnA(WrEnA), .WrEnB(WrEnB), .WrEnC(WrEnC), .row(row[1:0]), .col(col[1:0]),
        .dataIn(dataIn), .dataOut(dout1), .busy(busy_all[1]), .done(done_all[1])
    );

    tpu_lanes #(.DIM(4), .LANES(2)) dut4_l2 (
        .clk(clk), .rst(rst), .start(start), .mode_acc(mode_acc), .mode_sat(mode_sat),
        .WrEnA(WrEnA), .WrEnB(WrEnB), .WrEnC(WrEnC), .row(row[1:0]), .col(col[1:0]),
        .dataIn(dataIn), .dataOut(dout2), .busy(busy_all[2]), .done(done_all[2])
    );

    tpu_lanes #(.DIM(4), .LANES(4)) dut4_l4 (
        .clk(clk), .rst(rst), .start(start), .mode_acc(mode_acc), .mode_sat(mode_sat),
        .WrEnA(WrEnA), .WrEnB(WrEnB), .WrEnC(WrEnC), .row(row[1:0]), .col(col[1:0]),
        .dataIn(dataIn), .dataOut(dout3), .busy(busy_all[3]), .done(done_all[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] sel, input int r, input int c, input logic [31:0] d);
        {WrEnC, WrEnB, WrEnA} = sel;
        row    = 3'(r);
        col    = 3'(c);
        dataIn = d;
        @(posedge clk); #1;
        {WrEnC, WrEnB, WrEnA} = 3'b000;
    endtask

    task automatic rd(input int r, input int c);
        row = 3'(r);
        col = 3'(c);
        @(posedge clk); #1;
    endtask

    // Reference: each element is a plain dot product, then wrap or clamp.
    task automatic model_run(input int n, input bit macc, input bit msat);
        longint s;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = macc ? longint'(cm[i][j]) : 64'sd0;
                for (int k = 0; k < n; k++) s += longint'(am[i][k]) * longint'(bm[k][j]);
                if (msat && s > 64'sd2147483647)  s = 64'sd2147483647;
                if (msat && s < -64'sd2147483648) s = -64'sd2147483648;
                cm[i][j] = s[31:0];
            end
        end
    endtask

    task automatic load_ab_random(input int n);
        int v;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                v = int'($urandom_range(65534)) - 32767;
                am[i][j] = v;
                wr(3'b001, i, j, 32'(v));
                v = int'($urandom_range(65534)) - 32767;
                bm[i][j] = v;
                wr(3'b010, i, j, 32'(v));
            end
        end
    endtask

    task automatic check_c8(input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                rd(i, j);
                chk($sformatf("%s C[%0d][%0d]", tag, i, j), dout0, cm[i][j]);
            end
        end
    endtask

    // Pulse start, then watch every instance for a bounded number of cycles.
    task automatic run(input bit macc, input bit msat, input int disturb, input int abort_at);
        for (int d = 0; d < 4; d++) begin
            dcyc[d] = -1;
            np[d]   = 0;
        end
        mode_acc = macc;
        mode_sat = msat;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after start", {31'd0, busy_all[0]}, 32'd1);
        for (int c = 1; c <= 300; c++) begin
            if (c == disturb) begin
                WrEnA = 1'b1; row = 3'd0; col = 3'd0; dataIn = 32'd5; start = 1'b1;
            end
            if (c == abort_at) rst = 1'b1;
            @(posedge clk); #1;
            WrEnA = 1'b0; start = 1'b0; rst = 1'b0;
            if (dcyc[0] >= 0 && c == dcyc[0] + 1)
                chk("busy low after done", {31'd0, busy_all[0]}, 32'd0);
            for (int d = 0; d < 4; d++) begin
                if (done_all[d]) begin
                    if (dcyc[d] < 0) dcyc[d] = c;
                    np[d]++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode_acc = 1'b0; mode_sat = 1'b0;
        WrEnA = 1'b0; WrEnB = 1'b0; WrEnC = 1'b0;
        row = 3'd0; col = 3'd0; dataIn = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("reset busy", {31'd0, busy_all[0]}, 32'd0);
        chk("reset done", {31'd0, done_all[0]}, 32'd0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) cm[i][j] = 32'sd0;
        check_c8("reset");

        // Plain product with wrap.
        load_ab_random(8);
        run(1'b0, 1'b0, -1, -1);
        chk("cycles 8x8", 32'(dcyc[0]), 32'd144);
        chk("done pulses", 32'(np[0]), 32'd1);
        model_run(8, 1'b0, 1'b0);
        check_c8("mul");

        // Accumulate onto a random preload.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cm[i][j] = $urandom;
                wr(3'b100, i, j, cm[i][j]);
            end
        end
        check_c8("preload");
        load_ab_random(8);
        run(1'b1, 1'b0, -1, -1);
        model_run(8, 1'b1, 1'b0);
        check_c8("acc");

        // Saturating and wrapping on the largest positive operands.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    am[i][j] = 32767; bm[i][j] = 32767; cm[i][j] = 32'sh7FFFFFFF;
                    wr(3'b111, i, j, 32'h7FFFFFFF);
                    wr(3'b011, i, j, 32'h00007FFF);
                end
            end
            run(1'b1, (pass == 0), -1, -1);
            model_run(8, 1'b1, (pass == 0));
            check_c8(pass == 0 ? "sat" : "wrap");
        end

        // Write and start while busy are ignored.
        load_ab_random(8);
        run(1'b0, 1'b0, 20, -1);
        chk("busy-start done pulses", 32'(np[0]), 32'd1);
        model_run(8, 1'b0, 1'b0);
        check_c8("busy-ignore");

        // Reset mid-computation, then a normal run.
        load_ab_random(8);
        run(1'b0, 1'b0, -1, 50);
        chk("abort done pulses", 32'(np[0]), 32'd0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) cm[i][j] = 32'sd0;
        check_c8("abort");
        load_ab_random(8);
        run(1'b0, 1'b0, -1, -1);
        chk("cycles after abort", 32'(dcyc[0]), 32'd144);
        model_run(8, 1'b0, 1'b0);
        check_c8("post-abort");

        // DIM=4 lane sweep.
        load_ab_random(4);
        run(1'b0, 1'b0, -1, -1);
        chk("cycles 4x4 L1", 32'(dcyc[1]), 32'd80);
        chk("cycles 4x4 L2", 32'(dcyc[2]), 32'd40);
        chk("cycles 4x4 L4", 32'(dcyc[3]), 32'd20);
        model_run(4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                rd(i, j);
                chk($sformatf("L1 C[%0d][%0d]", i, j), dout1, cm[i][j]);
                chk($sformatf("L2 C[%0d][%0d]", i, j), dout2, cm[i][j]);
                chk($sformatf("L4 C[%0d][%0d]", i, j), dout3, cm[i][j]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
